pending_request_encoder: RTL and testbench

//  Inverse of the 2-to-4 address decoder: collects N request lines into a sticky pending set.

---
 rtl/pending_request_encoder_pkg.sv | 24 ++
 rtl/lowest_set_encoder.sv | 28 ++
 rtl/pending_request_encoder.sv | 97 +++++++++
 tb/tb_pending_request_encoder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pending_request_encoder_pkg.sv
// Shared types and constants for the pending request encoder.
// Holds the FSM state encoding, the default sizing and a clog2 helper.
package pending_request_encoder_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    localparam int DEFAULT_N  = 4;
    localparam int DEFAULT_AW = clog2(DEFAULT_N);

endpackage

// File: rtl/lowest_set_encoder.sv
// Rotating lowest-set-bit search: first set bit at index >= start, wrapping to 0.
// Purely combinational; start must be below N.
module lowest_set_encoder #(
    parameter int N  = 4,
    parameter int AW = 2
) (
    input  logic [N-1:0]  vector,
    input  logic [AW-1:0] start,
    output logic [AW-1:0] index,
    output logic          found
);

    logic [AW-1:0] pos;

    always_comb begin
        index = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = AW'((int'(start) + k) % N);
            if (!found && vector[pos]) begin
                index = pos;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pending_request_encoder.sv
// Collects request lines into a sticky pending set and issues one binary address per handshake.
// Latency: req to out_valid is 2 cycles minimum; back-to-back issue at one grant per cycle.
// Backpressure: address/out_valid hold while out_ready=0; requests keep accumulating as pending.
module pending_request_encoder
    import pending_request_encoder_pkg::*;
#(
    parameter int N           = DEFAULT_N,
    parameter int AW          = DEFAULT_AW,
    parameter int ROUND_ROBIN = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  req,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [AW-1:0] address,
    output logic [N-1:0]  pending,
    output logic          overrun
);

    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    state_t        state_q, state_d;
    logic [N-1:0]  pend_q, pend_d;
    logic [N-1:0]  clear_mask, held_mask;
    logic [AW-1:0] addr_q, last_q;
    logic [AW-1:0] start, sel;
    logic          sel_found, load, ovr_q, ovr_d;

    // Round-robin search begins just above the last granted index.
    assign start = (ROUND_ROBIN != 0) ? ((last_q == LAST_IDX) ? '0 : last_q + 1'b1) : '0;

    lowest_set_encoder #(
        .N  (N),
        .AW (AW)
    ) u_sel (
        .vector (pend_q),
        .start  (start),
        .index  (sel),
        .found  (sel_found)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    load    = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    if (sel_found) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A re-request of the bit being granted right now re-pends it without an overrun.
    always_comb begin
        clear_mask = load ? (N'(1) << sel) : '0;
        held_mask  = (out_valid && !out_ready) ? (N'(1) << address) : '0;
        pend_d     = (pend_q & ~clear_mask) | req;
        ovr_d      = |(req & ((pend_q & ~clear_mask) | held_mask));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            addr_q  <= '0;
            last_q  <= LAST_IDX;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            if (load) begin
                addr_q <= sel;
                last_q <= sel;
            end
        end
    end

    assign out_valid = (state_q == PRESENT);
    assign address   = addr_q;
    assign pending   = pend_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_pending_request_encoder.sv
// Directed bench: fixed-priority instance driven from a vector table, round-robin instance by hand.
module tb_pending_request_encoder;

    logic       clk;
    logic       reset_n;
    logic [3:0] req_f, req_r;
    logic       rdy_f, rdy_r;
    logic       valid_f, valid_r;
    logic [1:0] addr_f, addr_r;
    logic [3:0] pend_f, pend_r;
    logic       ovr_f, ovr_r;

    int n_tests;
    int n_fail;

    pending_request_encoder #(.N(4), .AW(2), .ROUND_ROBIN(0)) dut_fixed (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req_f),
        .out_ready (rdy_f),
        .out_valid (valid_f),
        .address   (addr_f),
        .pending   (pend_f),
        .overrun   (ovr_f)
    );

    pending_request_encoder #(.N(4), .AW(2), .ROUND_ROBIN(1)) dut_rr (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req_r),
        .out_ready (rdy_r),
        .out_valid (valid_r),
        .address   (addr_r),
        .pending   (pend_r),
        .overrun   (ovr_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic       exp_valid;
        logic [1:0] exp_addr;
        logic [3:0] exp_pend;
        logic       exp_ovr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] r, input logic rd, input logic v,
                                input logic [1:0] a, input logic [3:0] p, input logic o);
        vec_t t;
        t.req = r; t.rdy = rd; t.exp_valid = v; t.exp_addr = a; t.exp_pend = p; t.exp_ovr = o;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        req_f = 4'b1111; rdy_f = 1'b0;
        req_r = 4'b0000; rdy_r = 1'b0;

        // Reset held with requests asserted.
        step();
        step();
        chk("reset_valid", 32'(valid_f), 32'd0);
        chk("reset_pend",  32'(pend_f),  32'd0);
        chk("reset_ovr",   32'(ovr_f),   32'd0);
        chk("reset_addr",  32'(addr_f),  32'd0);
        reset_n = 1'b1;
        req_f = 4'b0000; rdy_f = 1'b1;
        step();
        step();
        chk("idle_valid", 32'(valid_f), 32'd0);
        chk("idle_pend",  32'(pend_f),  32'd0);

        //                req      rdy   valid addr   pend     ovr
        // single request
        tbl.push_back(mk(4'b0100, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b0));
        tbl.push_back(mk(4'b0000, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0));
        tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0));
        // fixed priority burst
        tbl.push_back(mk(4'b1011, 1'b1, 1'b0, 2'd2, 4'b1011, 1'b0));
        tbl.push_back(mk(4'b0000, 1'b1, 1'b1, 2'd0, 4'b1010, 1'b0));
        tbl.push_back(mk(4'b0000, 1'b1, 1'b1, 2'd1, 4'b1000, 1'b0));
        tbl.push_back(mk(4'b0000, 1'b1, 1'b1, 2'd3, 4'b0000, 1'b0));
        tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0));
        // stall, no preemption, overrun on held grant
        tbl.push_back(mk(4'b0100, 1'b0, 1'b0, 2'd3, 4'b0100, 1'b0));
        tbl.push_back(mk(4'b0000, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0));
        tbl.push_back(mk(4'b0001, 1'b0, 1'b1, 2'd2, 4'b0001, 1'b0));
        tbl.push_back(mk(4'b0100, 1'b0, 1'b1, 2'd2, 4'b0101, 1'b1));
        tbl.push_back(mk(4'b0000, 1'b0, 1'b1, 2'd2, 4'b0101, 1'b0));
        tbl.push_back(mk(4'b0000, 1'b1, 1'b1, 2'd0, 4'b0100, 1'b0));
        tbl.push_back(mk(4'b0000, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0));
        tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0));
        // re-request in grant cycle re-pends silently; on pending bit it overruns
        tbl.push_back(mk(4'b1000, 1'b0, 1'b0, 2'd2, 4'b1000, 1'b0));
        tbl.push_back(mk(4'b1000, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b0));
        tbl.push_back(mk(4'b1000, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b1));
        tbl.push_back(mk(4'b0000, 1'b1, 1'b1, 2'd3, 4'b0000, 1'b0));
        tbl.push_back(mk(4'b0000, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0));

        foreach (tbl[i]) begin
            req_f = tbl[i].req;
            rdy_f = tbl[i].rdy;
            step();
            chk($sformatf("v%0d_valid", i), 32'(valid_f), 32'(tbl[i].exp_valid));
            chk($sformatf("v%0d_addr",  i), 32'(addr_f),  32'(tbl[i].exp_addr));
            chk($sformatf("v%0d_pend",  i), 32'(pend_f),  32'(tbl[i].exp_pend));
            chk($sformatf("v%0d_ovr",   i), 32'(ovr_f),   32'(tbl[i].exp_ovr));
        end
        req_f = 4'b0000;

        // Round robin with all requests held.
        req_r = 4'b1111;
        rdy_r = 1'b1;
        step();
        chk("rr_first_valid", 32'(valid_r), 32'd0);
        chk("rr_first_ovr",   32'(ovr_r),   32'd0);
        begin
            logic [1:0] rr_exp [5];
            rr_exp[0] = 2'd0; rr_exp[1] = 2'd1; rr_exp[2] = 2'd2;
            rr_exp[3] = 2'd3; rr_exp[4] = 2'd0;
            for (int i = 0; i < 5; i++) begin
                step();
                chk($sformatf("rr%0d_valid", i), 32'(valid_r), 32'd1);
                chk($sformatf("rr%0d_addr",  i), 32'(addr_r),  32'(rr_exp[i]));
            end
        end
        req_r = 4'b0000;
        rdy_r = 1'b0;

        // Async reset between edges with pending=0110 and a grant presented.
        req_f = 4'b0111;
        rdy_f = 1'b0;
        step();
        req_f = 4'b0000;
        step();
        chk("pre_rst_valid", 32'(valid_f), 32'd1);
        chk("pre_rst_pend",  32'(pend_f),  32'b0110);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid",    32'(valid_f), 32'd0);
        chk("arst_pend",     32'(pend_f),  32'd0);
        chk("arst_addr",     32'(addr_f),  32'd0);
        chk("arst_rr_valid", 32'(valid_r), 32'd0);
        chk("arst_rr_pend",  32'(pend_r),  32'd0);
        #2;
        reset_n = 1'b1;
        step();
        step();
        chk("post_rst_valid", 32'(valid_f), 32'd0);
        chk("post_rst_pend",  32'(pend_f),  32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
